// File: rtl/imm_table_unit_pkg.sv
// Shared constants for the immediate table: default values, mode and FSM encodings.
package imm_pkg;

    localparam logic IMM_MODE_TABLE  = 1'b0;
    localparam logic IMM_MODE_DIRECT = 1'b1;

    typedef enum logic {
        IMM_IDLE   = 1'b0,
        IMM_RELOAD = 1'b1
    } imm_state_e;

    // Returns the default for an entry, masked to data_w bits (caller slices to width).
    function automatic logic [63:0] imm_default(input int idx, input int data_w);
        logic [63:0] v;
        case (idx)
            0:       v = 64'd0;
            1:       v = 64'd1;
            2:       v = 64'd32;
            3:       v = 64'd64;
            4:       v = 64'd96;
            5:       v = '1;
            6:       v = 64'd144;
            7:       v = 64'd9;
            default: v = 64'd0;
        endcase
        if (data_w < 64)
            v = v & ((64'd1 << data_w) - 64'd1);
        return v;
    endfunction

endpackage

// File: rtl/imm_table_unit_if.sv
// Request/response bundle between decode and the immediate table.
interface imm_table_unit_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              rd_en;
    logic              mode;
    logic [IDX_W-1:0]  imin;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              reload;
    logic [DATA_W-1:0] imout;
    logic              imvalid;
    logic              busy;

    modport master (
        output rd_en, mode, imin, wr_en, wr_idx, wr_data, reload,
        input  imout, imvalid, busy
    );

    modport slave (
        input  rd_en, mode, imin, wr_en, wr_idx, wr_data, reload,
        output imout, imvalid, busy
    );
endinterface

// File: rtl/imm_table_unit_reload_seq.sv
// Restore-defaults sequencer: walks every entry once, one per cycle, while busy.
module imm_reload_seq
    import imm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              reload,
    output logic              busy,
    output logic              ld_en,
    output logic [IDX_W-1:0]  ld_idx,
    output logic [DATA_W-1:0] ld_data
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST = '1;

    logic [DEPTH-1:0][DATA_W-1:0] defs;
    imm_state_e       state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_def
        localparam logic [63:0] DV = imm_default(g, DATA_W);
        assign defs[g] = DV[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IMM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter wraps to zero on the last entry, so completion costs no extra cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_en     = 1'b0;
        case (state)
            IMM_IDLE: begin
                cnt_nxt = '0;
                if (reload)
                    state_nxt = IMM_RELOAD;
            end
            IMM_RELOAD: begin
                ld_en   = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST)
                    state_nxt = IMM_IDLE;
            end
            default: state_nxt = IMM_IDLE;
        endcase
    end

    assign busy    = (state == IMM_RELOAD);
    assign ld_idx  = cnt;
    assign ld_data = defs[cnt];

endmodule

// File: rtl/imm_table_unit.sv
// Writable immediate-constant table with registered, valid-qualified output.
module imm_table_unit
    import imm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input logic            clk,
    input logic            rstn,
    imm_table_unit_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][DATA_W-1:0] tbl, defs;
    logic              busy, ld_en, rd_fire, wr_fire;
    logic [IDX_W-1:0]  ld_idx;
    logic [DATA_W-1:0] ld_data, sext, rd_val, imout_q;
    logic              imvalid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_def
        localparam logic [63:0] DV = imm_default(g, DATA_W);
        assign defs[g] = DV[DATA_W-1:0];
    end

    imm_reload_seq #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_seq (
        .clk     (clk),
        .rstn    (rstn),
        .reload  (bus.reload),
        .busy    (busy),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
    );

    assign rd_fire = bus.rd_en && !busy;
    assign wr_fire = bus.wr_en && !busy;
    assign sext    = {{(DATA_W-IDX_W){bus.imin[IDX_W-1]}}, bus.imin};

    // Same-index write in table mode is forwarded so the reader sees the new value.
    always_comb begin
        rd_val = tbl[bus.imin];
        if (bus.mode == IMM_MODE_DIRECT)
            rd_val = sext;
        else if (wr_fire && bus.wr_idx == bus.imin)
            rd_val = bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tbl       <= defs;
            imout_q   <= '0;
            imvalid_q <= 1'b0;
        end else begin
            imvalid_q <= rd_fire;
            if (rd_fire)
                imout_q <= rd_val;
            if (ld_en)
                tbl[ld_idx] <= ld_data;
            else if (wr_fire)
                tbl[bus.wr_idx] <= bus.wr_data;
        end
    end

    assign bus.imout   = imout_q;
    assign bus.imvalid = imvalid_q;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_imm_table_unit.sv
// Directed bench for imm_table_unit: scoreboarded reads on a 16x8 instance, spot checks on 8x16.
module tb_imm_table_unit;

    logic clk = 1'b0;
    logic rsta, rstb;
    always #5 clk = ~clk;

    imm_table_unit_if #(.DATA_W(16), .IDX_W(3)) ifa ();
    imm_table_unit_if #(.DATA_W(8),  .IDX_W(4)) ifb ();

    imm_table_unit #(.DATA_W(16), .IDX_W(3)) dut_a (.clk(clk), .rstn(rsta), .bus(ifa));
    imm_table_unit #(.DATA_W(8),  .IDX_W(4)) dut_b (.clk(clk), .rstn(rstb), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_v = 1'b0;
    logic [15:0] sb[$];
    logic [15:0] defa [8] = '{16'h0000, 16'h0001, 16'h0020, 16'h0040,
                              16'h0060, 16'hFFFF, 16'h0090, 16'h0009};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        ifa.rd_en = 0; ifa.mode = 0; ifa.imin = '0;
        ifa.wr_en = 0; ifa.wr_idx = '0; ifa.wr_data = '0; ifa.reload = 0;
        exp_v = 0;
    endtask

    task automatic rd_a(input logic m, input logic [2:0] idx, input logic [15:0] exp);
        ifa.rd_en = 1; ifa.mode = m; ifa.imin = idx;
        sb.push_back(exp);
        exp_v = 1;
    endtask

    task automatic wr_a(input logic [2:0] idx, input logic [15:0] d);
        ifa.wr_en = 1; ifa.wr_idx = idx; ifa.wr_data = d;
    endtask

    // One clock for instance A: checks the valid flag and retires any scoreboard entry.
    task automatic cyc_a(input string tag);
        @(posedge clk); #1;
        chk({tag, ".imvalid"}, {31'd0, ifa.imvalid}, {31'd0, exp_v});
        if (ifa.imvalid === 1'b1) begin
            if (sb.size() == 0) chk({tag, ".sb_underflow"}, 32'(sb.size()), 32'd1);
            else chk({tag, ".imout"}, {16'd0, ifa.imout}, {16'd0, sb.pop_front()});
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        clr_a();
    endtask

    task automatic cyc_b();
        @(posedge clk); #1;
    endtask

    task automatic read_all_a(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_a(0, 3'(i), defa[i]);
            cyc_a($sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        int n;
        clr_a();
        ifb.rd_en = 0; ifb.mode = 0; ifb.imin = '0; ifb.wr_en = 0;
        ifb.wr_idx = '0; ifb.wr_data = '0; ifb.reload = 0;
        rsta = 0; rstb = 0;
        cyc_a("rst");
        chk("rst.imout", {16'd0, ifa.imout}, 32'd0);
        chk("rst.busy", {31'd0, ifa.busy}, 32'd0);
        rsta = 1; rstb = 1;

        read_all_a("dflt");

        wr_a(2, 16'h1234); cyc_a("wr2");
        rd_a(0, 2, 16'h1234); cyc_a("rd2");
        wr_a(3, 16'hBEEF); rd_a(0, 3, 16'hBEEF); cyc_a("byp3");
        wr_a(6, 16'h5555); rd_a(0, 4, 16'h0060); cyc_a("nobyp4");

        rd_a(1, 3'b011, 16'h0003); cyc_a("sx3");
        rd_a(1, 3'b100, 16'hFFFC); cyc_a("sx4");
        rd_a(1, 3'b111, 16'hFFFF); cyc_a("sx7");
        wr_a(7, 16'h7777); rd_a(1, 3'b101, 16'hFFFD); cyc_a("sx5w");
        rd_a(0, 2, 16'h1234); cyc_a("post2");
        rd_a(0, 3, 16'hBEEF); cyc_a("post3");
        rd_a(0, 6, 16'h5555); cyc_a("post6");
        rd_a(0, 7, 16'h7777); cyc_a("post7");

        for (int i = 0; i < 8; i++) begin wr_a(3'(i), 16'hAAAA); cyc_a("fill"); end
        ifa.reload = 1; cyc_a("rl0");
        n = 0;
        while (ifa.busy === 1'b1 && n < 40) begin
            n++;
            ifa.rd_en = 1; ifa.imin = 3'd1; wr_a(0, 16'h5A5A); ifa.reload = 1;
            cyc_a("rlbusy");
        end
        chk("rl.busy_cycles", 32'(n), 32'd8);
        chk("rl.imout_hold", {16'd0, ifa.imout}, 32'h7777);
        read_all_a("rl");

        for (int i = 0; i < 8; i++) begin wr_a(3'(i), 16'hAAAA); cyc_a("fill2"); end
        rd_a(0, 7, 16'hAAAA); cyc_a("rd7a");
        ifa.reload = 1; cyc_a("rl2");
        cyc_a("rl2c1"); cyc_a("rl2c2"); cyc_a("rl2c3");
        rsta = 0; cyc_a("rl2rst");
        chk("rl2rst.busy", {31'd0, ifa.busy}, 32'd0);
        chk("rl2rst.imout", {16'd0, ifa.imout}, 32'd0);
        rsta = 1;
        read_all_a("rstmid");

        ifa.reload = 1; wr_a(4, 16'h1111); cyc_a("rlwr");
        n = 0;
        while (ifa.busy === 1'b1 && n < 40) begin n++; cyc_a("rlwrbusy"); end
        chk("rlwr.busy_cycles", 32'(n), 32'd8);
        rd_a(0, 4, 16'h0060); cyc_a("rlwr4");

        ifb.rd_en = 1; ifb.imin = 4'd5; cyc_b();
        chk("b.idx5", {24'd0, ifb.imout}, 32'hFF);
        chk("b.vld", {31'd0, ifb.imvalid}, 32'd1);
        ifb.imin = 4'd6; cyc_b();
        chk("b.idx6", {24'd0, ifb.imout}, 32'h90);
        ifb.imin = 4'd12; cyc_b();
        chk("b.idx12", {24'd0, ifb.imout}, 32'h00);
        ifb.imin = 4'd7; cyc_b();
        chk("b.idx7", {24'd0, ifb.imout}, 32'h09);
        ifb.mode = 1; ifb.imin = 4'b1010; cyc_b();
        chk("b.sx", {24'd0, ifb.imout}, 32'hFA);
        ifb.rd_en = 0; ifb.mode = 0;
        ifb.wr_en = 1; ifb.wr_idx = 4'd12; ifb.wr_data = 8'h3C; cyc_b();
        ifb.wr_en = 0; ifb.reload = 1; cyc_b();
        ifb.reload = 0;
        n = 0;
        while (ifb.busy === 1'b1 && n < 60) begin n++; cyc_b(); end
        chk("b.busy_cycles", 32'(n), 32'd16);
        ifb.rd_en = 1; ifb.imin = 4'd12; cyc_b();
        chk("b.rl12", {24'd0, ifb.imout}, 32'h00);
        ifb.rd_en = 0; cyc_b();
        chk("b.novld", {31'd0, ifb.imvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_table_unit.md
Name: imm_table_unit

Overview:
- Parametrised, writable immediate-constant table for the 10-bit CPU datapath.
- An instruction's immediate index selects a DATA_W-bit constant.
- Successor to the fixed 8-entry combinational immediate decoder; adds:
  - parametrised width and depth
  - runtime entry rewrite
  - a direct sign-extend mode
  - a registered, valid-qualified output
  - a sequenced restore-defaults operation
- Sits between instruction decode and the ALU B-operand mux.

Parameters:
- DATA_W, 16, width of each table entry and of IMOUT (min 8).
- IDX_W, 3, index width; table depth = 2**IDX_W (min 3).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RSTN  in  1  synchronous active-low reset.
- RD_EN  in  1  read request, sampled each cycle.
- MODE  in  1  0 = table lookup; 1 = direct: IMIN sign-extended to DATA_W.
- IMIN  in  IDX_W  immediate index / raw immediate.
- WR_EN  in  1  entry write strobe.
- WR_IDX  in  IDX_W  entry to write.
- WR_DATA  in  DATA_W  value to write.
- RELOAD  in  1  single-cycle pulse; restore all entries to defaults.
- IMOUT  out  DATA_W  registered immediate.
- IMVALID  out  1  IMOUT updated this cycle.
- BUSY  out  1  reload sequence in progress.

Behaviour:
- Reset (RSTN = 0 at a rising edge):
  - Every entry is loaded with its default.
  - IMOUT = 0, IMVALID = 0, BUSY = 0, FSM = IDLE, reload counter = 0.
  - Reset overrides all other inputs, including a reload in progress; the reload aborts.
- Defaults, per index:
  - 0 → 0
  - 1 → 1
  - 2 → 32
  - 3 → 64
  - 4 → 96
  - 5 → all ones (−1)
  - 6 → 144
  - 7 → 9
  - indices ≥ 8 → 0
  - All values are zero-extended, or truncated to DATA_W (except −1, which is all ones).
- Read:
  - Latency is 1 cycle. With RD_EN = 1 and BUSY = 0 at edge N, at edge N+1:
    - IMOUT = table[IMIN] if MODE = 0.
    - IMOUT = sign-extend(IMIN) if MODE = 1. Example: IMIN = 3'b101 gives 16'hFFFD.
    - IMVALID = 1.
  - Otherwise IMVALID = 0 and IMOUT holds its last value.
- Write:
  - WR_EN = 1 with BUSY = 0 updates table[WR_IDX] at the edge.
- Simultaneous read and write to the same index in table mode:
  - The write is bypassed: IMOUT = WR_DATA.
  - A different index reads the stored value.
  - In MODE = 1, writes still occur and do not affect IMOUT.
- FSM states: IDLE, RELOAD.
  - IDLE → RELOAD on RELOAD = 1. Counter = 0 and BUSY = 1 from the next cycle.
  - In RELOAD, each cycle: table[counter] ← default(counter), then counter increments.
  - At counter = 2**IDX_W − 1:
    - write the last entry and return to IDLE.
    - BUSY falls the cycle after.
    - Total BUSY duration = 2**IDX_W cycles.
- While BUSY = 1:
  - RD_EN and WR_EN are ignored. No IMVALID is raised and no write lands; the requester must retry.
  - RELOAD is ignored; no restart.
  - IMOUT holds.
- RELOAD with WR_EN in the same IDLE cycle:
  - The write lands.
  - The reload then overwrites it with the default.
- Counter wrap: the counter is IDX_W bits wide and its wrap equals completion; there is no extra cycle.

Decomposition:
- Shared package imm_pkg:
  - default-constant function imm_default(idx, DATA_W)
  - MODE encodings IMM_MODE_TABLE = 0, IMM_MODE_DIRECT = 1
  - FSM state encodings IMM_IDLE, IMM_RELOAD
- One natural sub-module: imm_reload_seq.
  - Contains the FSM, the counter and BUSY.
  - Drives the internal write index/data/enable into the table array.
- Table storage and the output register stay in the top level.

Test Plan:
- Reset then read indices 0–7 in MODE 0, back-to-back RD_EN.
  - IMOUT sequence 0, 1, 32, 64, 96, FFFF, 144, 9.
  - IMVALID high each cycle, 1-cycle latency.
- Write WR_IDX = 2, WR_DATA = 16'h1234; next cycle read IMIN = 2 → IMOUT = 1234.
  - Same-cycle write 3 = 16'hBEEF plus read 3 → IMOUT = BEEF.
- MODE 1 reads:
  - IMIN = 3'b011 → 0003.
  - IMIN = 3'b100 → FFFC.
  - IMIN = 3'b111 → FFFF.
  - Table contents are unchanged, verified by subsequent MODE 0 reads.
- Overwrite entries 0–7 with 16'hAAAA, then pulse RELOAD.
  - BUSY = 1 for exactly 8 cycles.
  - RD_EN and WR_EN during BUSY produce IMVALID = 0 and no table change.
  - Afterwards, reads return the defaults.
- Assert RSTN = 0 on reload cycle 4.
  - Next cycle: BUSY = 0, IMOUT = 0, IMVALID = 0.
  - All entries hold defaults, including 16'hAAAA entries not yet reloaded.
- DATA_W = 8, IDX_W = 4 instance:
  - Index 5 → 8'hFF; index 6 → 8'h90; index 12 → 0.
  - BUSY duration on RELOAD = 16 cycles.
